// File: rtl/zet_pic.sv
// 8-input fixed-priority interrupt controller (8259-style subset) for the Zet core.
// Edge-triggered requests, nested in-service masking, mask/EOI/status register port.
module zet_pic #(
    parameter logic [7:0] VBASE = 8'h08
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irq,
    output logic       intr,
    input  logic       inta,
    output logic [7:0] vector,
    input  logic       wr,
    input  logic       addr,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o
);

    logic [7:0] irq_d_q, irq_d_d;
    logic [7:0] irr_q, irr_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] imr_q, imr_d;
    logic [7:0] vector_q, vector_d;
    logic       rsel_q, rsel_d;
    logic       intr_q, intr_d;

    logic [7:0] req;
    logic [3:0] pend;
    logic [3:0] serv;
    logic       ack_ok;
    logic [7:0] ack_bit;
    logic [7:0] eoi_clr;

    always_comb begin
        req  = irr_q & ~imr_q;
        pend = 4'd8;
        serv = 4'd8;
        for (int unsigned i = 0; i < 8; i++) begin
            if (req[i] && pend == 4'd8) pend = 4'(i);
            if (isr_q[i] && serv == 4'd8) serv = 4'(i);
        end
        // pend == 8 means nothing pending, which can never be below serv
        ack_ok = pend < serv;

        ack_bit = '0;
        if (inta && ack_ok) ack_bit[pend[2:0]] = 1'b1;

        eoi_clr = '0;
        rsel_d  = rsel_q;
        if (wr && !addr) begin
            if (dat_i == 8'h20) begin
                if (!serv[3]) eoi_clr[serv[2:0]] = 1'b1;
            end else if (dat_i[7:3] == 5'b01100) begin
                eoi_clr[dat_i[2:0]] = 1'b1;
            end else if (dat_i == 8'h0A) begin
                rsel_d = 1'b0;
            end else if (dat_i == 8'h0B) begin
                rsel_d = 1'b1;
            end
        end

        imr_d   = (wr && addr) ? dat_i : imr_q;
        irq_d_d = irq;
        // a fresh edge overrides the acknowledge clear; the ack set overrides EOI
        irr_d   = (irr_q & ~ack_bit) | (irq & ~irq_d_q);
        isr_d   = (isr_q & ~eoi_clr) | ack_bit;
        intr_d  = ack_ok;

        vector_d = vector_q;
        if (inta) vector_d = ack_ok ? VBASE + {5'b0, pend[2:0]} : VBASE + 8'd7;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_d_q  <= '0;
            irr_q    <= '0;
            isr_q    <= '0;
            imr_q    <= '1;
            vector_q <= '0;
            rsel_q   <= 1'b0;
            intr_q   <= 1'b0;
        end else begin
            irq_d_q  <= irq_d_d;
            irr_q    <= irr_d;
            isr_q    <= isr_d;
            imr_q    <= imr_d;
            vector_q <= vector_d;
            rsel_q   <= rsel_d;
            intr_q   <= intr_d;
        end
    end

    assign intr   = intr_q;
    assign vector = vector_q;
    assign dat_o  = addr ? imr_q : (rsel_q ? isr_q : irr_q);

endmodule

// File: tb/tb_zet_pic.sv
// Scoreboard bench for zet_pic: driver predicts outputs from a behavioural model,
// monitor compares after every clock edge and every reset assertion.
module tb_zet_pic;
    localparam logic [7:0] VB = 8'h08;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] irq = '0;
    logic       intr;
    logic       inta = 1'b0;
    logic [7:0] vector;
    logic       wr = 1'b0;
    logic       addr = 1'b0;
    logic [7:0] dat_i = '0;
    logic [7:0] dat_o;

    zet_pic #(.VBASE(VB)) dut (
        .clk(clk), .rst(rst), .irq(irq), .intr(intr), .inta(inta),
        .vector(vector), .wr(wr), .addr(addr), .dat_i(dat_i), .dat_o(dat_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       intr;
        logic [7:0] vector;
        logic [7:0] dat_o;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   checks = 0;

    bit [7:0] m_irr, m_isr, m_imr, m_prev, m_vec;
    bit       m_rsel, m_intr;

    function automatic int lowest(bit [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        e.intr   = m_intr;
        e.vector = m_vec;
        e.dat_o  = addr ? m_imr : (m_rsel ? m_isr : m_irr);
        return e;
    endfunction

    task automatic model_reset();
        m_irr = '0; m_isr = '0; m_imr = 8'hFF; m_prev = '0;
        m_vec = '0; m_rsel = 1'b0; m_intr = 1'b0;
    endtask

    task automatic model_step(input bit [7:0] i_irq, input bit i_inta, input bit i_wr,
                              input bit i_addr, input bit [7:0] i_dat);
        int pend, serv;
        bit ok;
        bit [7:0] irr_n, isr_n;
        pend  = lowest(m_irr & ~m_imr);
        serv  = lowest(m_isr);
        ok    = (pend < 8) && (pend < serv);
        irr_n = m_irr;
        isr_n = m_isr;
        if (i_wr && !i_addr) begin
            if (i_dat == 8'h20) begin
                if (serv < 8) isr_n[serv] = 1'b0;
            end else if (i_dat >= 8'h60 && i_dat <= 8'h67) begin
                isr_n[i_dat[2:0]] = 1'b0;
            end else if (i_dat == 8'h0A) begin
                m_rsel = 1'b0;
            end else if (i_dat == 8'h0B) begin
                m_rsel = 1'b1;
            end
        end
        if (i_inta) begin
            if (ok) begin
                isr_n[pend] = 1'b1;
                irr_n[pend] = 1'b0;
                m_vec = 8'(int'(VB) + pend);
            end else begin
                m_vec = 8'(int'(VB) + 7);
            end
        end
        for (int i = 0; i < 8; i++) if (i_irq[i] && !m_prev[i]) irr_n[i] = 1'b1;
        if (i_wr && i_addr) m_imr = i_dat;
        m_intr = ok;
        m_irr  = irr_n;
        m_isr  = isr_n;
        m_prev = i_irq;
    endtask

    task automatic cyc(input bit [7:0] i_irq, input bit i_inta, input bit i_wr,
                       input bit i_addr, input bit [7:0] i_dat);
        @(negedge clk);
        irq = i_irq; inta = i_inta; wr = i_wr; addr = i_addr; dat_i = i_dat;
        if (rst) model_step(i_irq, i_inta, i_wr, i_addr, i_dat);
        sb.push_back(expect_now());
        vectors++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(irq, 1'b0, 1'b0, addr, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        inta = 1'b0; wr = 1'b0;
        rst = 1'b0;
        model_reset();
        sb.push_back(expect_now());
        vectors++;
        cyc(irq, 1'b0, 1'b0, 1'b1, 8'h00);
        cyc(irq, 1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #3 rst = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or negedge rst);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks += 3;
                if (intr !== e.intr) begin
                    miscompares++;
                    $display("FAIL intr: got %0b want %0b at %0t", intr, e.intr, $time);
                end
                if (vector !== e.vector) begin
                    miscompares++;
                    $display("FAIL vector: got %02h want %02h at %0t", vector, e.vector, $time);
                end
                if (dat_o !== e.dat_o) begin
                    miscompares++;
                    $display("FAIL dat_o(addr=%0b): got %02h want %02h at %0t", addr, dat_o, e.dat_o, $time);
                end
            end
        end
    end

    initial begin : driver
        bit [7:0] r_irq, r_dat;
        bit       r_inta, r_wr, r_addr, last_inta;
        model_reset();
        do_reset();

        // single request, acknowledge, EOI
        cyc(8'h00, 0, 1, 1, 8'h00);
        cyc(8'h01, 0, 0, 0, 8'h00);
        idle(2);
        cyc(8'h00, 1, 0, 0, 8'h00);
        cyc(8'h00, 0, 1, 0, 8'h0B);
        idle(2);
        cyc(8'h00, 0, 1, 0, 8'h20);
        idle(1);

        // two simultaneous requests, nesting blocks the lower one until EOI
        cyc(8'h0A, 0, 0, 0, 8'h00);
        idle(2);
        cyc(8'h0A, 1, 0, 0, 8'h00);
        idle(3);
        cyc(8'h0A, 0, 1, 0, 8'h20);
        idle(2);
        cyc(8'h00, 1, 0, 0, 8'h00);
        idle(2);

        // higher priority nests over ISR[3]; IRQ5 waits for two EOIs
        cyc(8'h01, 0, 0, 0, 8'h00);
        idle(2);
        cyc(8'h01, 1, 0, 0, 8'h00);
        cyc(8'h21, 0, 0, 0, 8'h00);
        idle(3);
        cyc(8'h21, 0, 1, 0, 8'h20);
        idle(2);
        cyc(8'h21, 0, 1, 0, 8'h20);
        idle(2);
        cyc(8'h21, 1, 0, 0, 8'h00);
        cyc(8'h00, 0, 1, 0, 8'h65);
        idle(1);

        // mask written right before acknowledge gives a spurious vector
        cyc(8'h10, 0, 0, 0, 8'h00);
        idle(2);
        cyc(8'h10, 0, 1, 1, 8'h10);
        cyc(8'h10, 1, 0, 0, 8'h00);
        cyc(8'h10, 0, 1, 0, 8'h0A);
        idle(2);
        cyc(8'h10, 0, 1, 1, 8'h00);
        idle(2);
        cyc(8'h10, 1, 0, 0, 8'h00);
        cyc(8'h10, 0, 1, 0, 8'h64);

        // held level does not re-request; drop and re-raise does
        cyc(8'h40, 0, 0, 0, 8'h00);
        idle(2);
        cyc(8'h40, 1, 0, 0, 8'h00);
        cyc(8'h40, 0, 1, 0, 8'h66);
        idle(3);
        cyc(8'h00, 0, 0, 0, 8'h00);
        cyc(8'h40, 0, 0, 0, 8'h00);
        idle(2);
        cyc(8'h40, 1, 0, 0, 8'h00);
        idle(1);

        // edge on the bit being acknowledged keeps it requested; reset while active
        cyc(8'h00, 0, 0, 0, 8'h00);
        cyc(8'h04, 0, 0, 0, 8'h00);
        idle(1);
        cyc(8'h00, 0, 0, 0, 8'h00);
        cyc(8'h04, 1, 0, 0, 8'h00);
        idle(2);
        do_reset();
        idle(2);

        last_inta = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                last_inta = 1'b0;
                continue;
            end
            r_irq = irq;
            for (int b = 0; b < 8; b++) if ($urandom_range(0, 9) == 0) r_irq[b] = ~r_irq[b];
            r_inta = !last_inta && (m_intr ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0));
            r_wr   = ($urandom_range(0, 7) == 0);
            r_addr = $urandom_range(0, 1) == 1;
            r_dat  = 8'($urandom);
            if (r_wr && r_addr && $urandom_range(0, 1) == 1) r_dat = 8'h00;
            if (r_wr && !r_addr) begin
                case ($urandom_range(0, 4))
                    0, 1: r_dat = 8'h20;
                    2: r_dat = 8'h60 | 8'($urandom_range(0, 7));
                    3: r_dat = ($urandom_range(0, 1) == 1) ? 8'h0B : 8'h0A;
                    default: ;
                endcase
            end
            cyc(r_irq, r_inta, r_wr, r_addr, r_dat);
            last_inta = r_inta;
        end

        cyc(irq, 1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
